lsu_sram_ctrl: RTL

- Parametrised, handshaked successor to the MEM-stage load/store formatter.
- Accepts one load/store per instruction from the MEM stage and checks alignment (AdEL/AdES).
- Generates byte strobes and replicated write data; drives one transaction on an sram-like bus (req/addr_ok/data_ok).
- Stalls the pipeline until data returns, then sign- or zero-extends the load result; a flush cancels the result.

---
 rtl/lsu_sram_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/lsu_sram_ctrl.sv
// MEM-stage load/store unit driving a single-outstanding sram-like bus.
// Checks alignment, builds strobes and replicated store data, and formats load results.
module lsu_sram_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_en,
  input  logic                mem_wr,
  input  logic [1:0]          mem_size,
  input  logic                mem_unsigned,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic                flush,
  output logic                stall,
  output logic [DATA_W-1:0]   load_data,
  output logic                done,
  output logic                adel,
  output logic                ades,
  output logic [ADDR_W-1:0]   bad_vaddr,
  output logic                sram_req,
  output logic                sram_wr,
  output logic [1:0]          sram_size,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W/8-1:0] sram_wstrb,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic                sram_addr_ok,
  input  logic                sram_data_ok,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state_reg, state_next;

  logic              misaligned, req_err, accept, cancel_now, xfer_done;
  logic [NB-1:0]     strb_next;
  logic [DATA_W-1:0] wdata_next;
  logic [OFF_W-1:0]  lane_next;
  logic [DATA_W-1:0] rdata_fmt, rdata_shift;
  int                nb_bytes, lane_lo, nb_bits;

  logic              wr_reg, uns_reg, cancel_reg;
  logic [1:0]        size_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [NB-1:0]     strb_reg;
  logic [DATA_W-1:0] wdata_reg, load_data_reg;
  logic [OFF_W-1:0]  lane_reg;

  always_comb begin
    misaligned = 1'b0;
    case (mem_size)
      2'd1:    misaligned = mem_addr[0];
      2'd2:    misaligned = |mem_addr[1:0];
      2'd3:    misaligned = (DATA_W == 32) || (|mem_addr[2:0]);
      default: misaligned = 1'b0;
    endcase
  end

  assign req_err    = (state_reg == IDLE) && mem_en && misaligned;
  assign accept     = (state_reg == IDLE) && mem_en && !misaligned && !flush;
  assign cancel_now = cancel_reg || flush;
  assign xfer_done  = ((state_reg == REQ) && sram_addr_ok && sram_data_ok) ||
                      ((state_reg == WAIT) && sram_data_ok);

  // Lowest lane of the group covered by the access; the group is contiguous
  // in both endiannesses, only its position mirrors.
  always_comb begin
    nb_bytes = 1 << mem_size;
    if (nb_bytes > NB) nb_bytes = NB;
    lane_lo = BIG_ENDIAN ? (NB - int'(mem_addr[OFF_W-1:0]) - nb_bytes)
                         : int'(mem_addr[OFF_W-1:0]);
    lane_next  = lane_lo[OFF_W-1:0];
    strb_next  = '0;
    wdata_next = '0;
    for (int i = 0; i < NB; i++) begin
      if (i >= lane_lo && i < lane_lo + nb_bytes) strb_next[i] = 1'b1;
      wdata_next[i*8 +: 8] = mem_wdata[(i % nb_bytes)*8 +: 8];
    end
  end

  always_comb begin
    rdata_shift = sram_rdata >> {lane_reg, 3'b000};
    nb_bits = 8 << size_reg;
    if (nb_bits > DATA_W) nb_bits = DATA_W;
    rdata_fmt = '0;
    for (int i = 0; i < DATA_W; i++) begin
      rdata_fmt[i] = (i < nb_bits) ? rdata_shift[i]
                                   : (!uns_reg && rdata_shift[nb_bits-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = REQ;
      REQ: begin
        if (sram_addr_ok) begin
          if (sram_data_ok) state_next = cancel_now ? IDLE : DONE;
          else              state_next = WAIT;
        end
      end
      WAIT: if (sram_data_ok) state_next = cancel_now ? IDLE : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall     = accept || (state_reg == REQ) || (state_reg == WAIT);
    done      = (state_reg == DONE);
    sram_req  = (state_reg == REQ);
    adel      = req_err && !mem_wr;
    ades      = req_err && mem_wr;
    bad_vaddr = req_err ? mem_addr : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_reg        <= 1'b0;
      uns_reg       <= 1'b0;
      size_reg      <= 2'd0;
      addr_reg      <= '0;
      strb_reg      <= '0;
      wdata_reg     <= '0;
      lane_reg      <= '0;
      cancel_reg    <= 1'b0;
      load_data_reg <= '0;
    end else begin
      if (accept) begin
        wr_reg    <= mem_wr;
        uns_reg   <= mem_unsigned;
        size_reg  <= mem_size;
        addr_reg  <= mem_addr;
        strb_reg  <= mem_wr ? strb_next : '0;
        wdata_reg <= wdata_next;
        lane_reg  <= lane_next;
      end
      // A flushed transaction still finishes on the bus; only its result is dropped.
      if (state_next == IDLE)
        cancel_reg <= 1'b0;
      else if (flush && (state_reg == REQ || state_reg == WAIT))
        cancel_reg <= 1'b1;
      if (xfer_done && !cancel_now && !wr_reg)
        load_data_reg <= rdata_fmt;
    end
  end

  assign load_data  = load_data_reg;
  assign sram_wr    = wr_reg;
  assign sram_size  = size_reg;
  assign sram_addr  = addr_reg;
  assign sram_wstrb = strb_reg;
  assign sram_wdata = wdata_reg;

endmodule
